button_event_decoder: RTL and testbench
=======================================

Name: button_event_decoder

Overview:
- Consumer of a debounced button level. It sits directly downstream of the 1 ms debouncer's clean output.
- Converts the level into one-cycle event pulses: press, release, long-press, auto-repeat and, optionally, double-click.
- Drives UI/control logic so that no other block in the design re-implements button timing.

Parameters:
- CNT_W, 27: width of the internal cycle counter.
- LONG_CYCLES, 100_000_000: hold time that triggers a long press (1 s at 100 MHz). Legal range is 2 to 2^CNT_W-1.
- REPEAT_CYCLES, 20_000_000: auto-repeat period after a long press. A value of 0 disables repeat.
- DCLICK_CYCLES, 30_000_000: maximum release-to-press gap for a double click. Used only with DOUBLE_CLICK_EN.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-low reset.
- clean, input, 1: debounced button level, synchronous to clk; 1 means pressed.
- press, output, 1: one-cycle pulse on a press.
- release, output, 1: one-cycle pulse on a release.
- long_press, output, 1: one-cycle pulse when the hold reaches LONG_CYCLES.
- repeat, output, 1: one-cycle pulse every REPEAT_CYCLES while held after a long press.
- held, output, 1: level, high while the FSM considers the button pressed.
- double_click, output, 1: one-cycle pulse on the second press of a double click.

Behaviour:
- Reset:
  - rst=0 asynchronously clears all outputs and the counter to 0.
  - FSM goes to LOCKOUT.
  - Reset mid-operation aborts any event; no release pulse is issued.
- All outputs are registered. Event latency is 1 clk: a pulse is high in the cycle following the clk edge at which the triggering clean value is first sampled.
- LOCKOUT:
  - No events are generated.
  - Moves to IDLE on the first edge at which clean=0 is sampled.
  - A button held through reset therefore never produces press, long_press or release.
- IDLE:
  - clean=1 sampled: press=1, held=1, count<=0, move to PRESSED.
- PRESSED:
  - clean=1: count<=count+1.
  - When count==LONG_CYCLES-1 while clean=1: long_press=1, count<=0, move to LONG_HELD. The long_press pulse occurs exactly LONG_CYCLES cycles after the press pulse.
  - clean=0: release=1, held=0, move to IDLE, or to GAP when DOUBLE_CLICK_EN is enabled and the current press is not already the second press of a double click.
- LONG_HELD:
  - clean=1 and REPEAT_CYCLES!=0: count increments; at count==REPEAT_CYCLES-1, repeat=1 and count<=0.
  - clean=0: release=1, held=0, move to IDLE. The GAP state is never entered from a long press.
- Simultaneous events:
  - clean=0 sampled on the same edge at which a threshold would be reached: release wins, and no long_press or repeat is generated.
- Width rules:
  - count is CNT_W bits wide, unsigned, and never wraps; it is cleared on every threshold and on every state entry.
- held:
  - Equals 1 exactly in PRESSED and LONG_HELD.
- Pulse rules:
  - No pulse lasts more than 1 cycle.
  - press and release are never high in the same cycle.

Optional Feature:
- DOUBLE_CLICK_EN defined:
  - Adds the GAP state, entered after release from a short press (PRESSED). count<=0 on entry.
  - In GAP, clean=1 before count reaches DCLICK_CYCLES-1: press=1 and double_click=1 in the same cycle, held=1, move to PRESSED with the second-press flag set. The release of that second press returns to IDLE, so a triple click never yields a second double_click.
  - count reaching DCLICK_CYCLES-1 with clean=0: move to IDLE silently.
- DOUBLE_CLICK_EN undefined:
  - No GAP state and no DCLICK counter logic.
  - The double_click port remains and is tied to 0.

Test Plan (bench parameters LONG_CYCLES=10, REPEAT_CYCLES=4, DCLICK_CYCLES=6):
1. Lockout: hold clean=1 through reset, deassert rst, keep clean=1 for 20 cycles, then drive clean=0 -> all outputs stay 0. Then drive clean=1 -> press pulses one cycle later.
2. Short press: clean=1 for 5 cycles then 0 -> press in cycle 1, held high for 5 cycles, release in cycle 6, long_press never asserted.
3. Long press with repeat: clean=1 for 25 cycles -> long_press 10 cycles after press, repeat at +14, +18 and +22, then release. Repeat the run with REPEAT_CYCLES=0 -> no repeat pulses.
4. Threshold race: clean=0 sampled on the edge at which count==9 -> release=1, long_press=0.
5. Double click, with DOUBLE_CLICK_EN: press 3 cycles, release 3 cycles, press again -> double_click and press in the same cycle. With a 7-cycle gap instead -> plain press, double_click=0. A third quick press after a double click -> no double_click.
6. Mid-hold reset: assert rst=0 while in LONG_HELD -> held, count and all pulses go to 0 immediately; no release pulse. After rst=1 with clean=1 still held -> no events until clean=0 is seen.

Source files
------------

// File: rtl/button_event_decoder.sv
// button_event_decoder: turns a debounced button level into press/release/long/repeat/double-click pulses
//   clk           system clock
//   rst           asynchronous active-low reset
//   clean         debounced button level, 1 = pressed
//   press         one-cycle pulse on a press
//   release_pulse one-cycle pulse on a release
//   long_press    one-cycle pulse when the hold reaches LONG_CYCLES
//   repeat_pulse  one-cycle pulse every REPEAT_CYCLES while held after a long press
//   held          level, high while pressed
//   double_click  one-cycle pulse on the second press of a double click (0 unless DOUBLE_CLICK_EN)
// Optional feature macro: DOUBLE_CLICK_EN
module button_event_decoder #(
  parameter int CNT_W         = 27,
  parameter int LONG_CYCLES   = 100_000_000,
  parameter int REPEAT_CYCLES = 20_000_000,
  parameter int DCLICK_CYCLES = 30_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clean,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse,
  output logic held,
  output logic double_click
);
`ifdef DOUBLE_CLICK_EN
  typedef enum logic [2:0] {LOCKOUT, IDLE, PRESSED, LONG_HELD, GAP} state_t;
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);
  logic second, second_d, dclick_d;
`else
  typedef enum logic [1:0] {LOCKOUT, IDLE, PRESSED, LONG_HELD} state_t;
`endif
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES == 0 ? 0 : REPEAT_CYCLES - 1);
  state_t state, state_d;
  logic [CNT_W-1:0] count, count_d;
  logic press_d, release_d, long_d, repeat_d, held_d;
  always_comb begin
    state_d   = state;
    count_d   = count;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
`ifdef DOUBLE_CLICK_EN
    second_d  = second;
    dclick_d  = 1'b0;
`endif
    case (state)
      LOCKOUT: if (!clean) state_d = IDLE;
      IDLE: if (clean) begin
        press_d = 1'b1;
        count_d = '0;
        state_d = PRESSED;
`ifdef DOUBLE_CLICK_EN
        second_d = 1'b0;
`endif
      end
      PRESSED: if (!clean) begin
        // release takes priority over a threshold reached on the same edge
        release_d = 1'b1;
        count_d   = '0;
`ifdef DOUBLE_CLICK_EN
        state_d   = second ? IDLE : GAP;
`else
        state_d   = IDLE;
`endif
      end else if (count == LONG_LAST) begin
        long_d  = 1'b1;
        count_d = '0;
        state_d = LONG_HELD;
      end else count_d = count + 1'b1;
      LONG_HELD: if (!clean) begin
        release_d = 1'b1;
        count_d   = '0;
        state_d   = IDLE;
      end else if (REPEAT_CYCLES != 0) begin
        repeat_d = count == REP_LAST;
        count_d  = count == REP_LAST ? '0 : count + 1'b1;
      end
`ifdef DOUBLE_CLICK_EN
      GAP: if (clean) begin
        // a press landing on the final gap cycle is too late to count as a double click
        press_d  = 1'b1;
        dclick_d = count != DCLICK_LAST;
        second_d = count != DCLICK_LAST;
        count_d  = '0;
        state_d  = PRESSED;
      end else if (count == DCLICK_LAST) begin
        count_d = '0;
        state_d = IDLE;
      end else count_d = count + 1'b1;
`endif
      default: state_d = LOCKOUT;
    endcase
    held_d = state_d == PRESSED || state_d == LONG_HELD;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state         <= LOCKOUT;
      count         <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      state         <= state_d;
      count         <= count_d;
      press         <= press_d;
      release_pulse <= release_d;
      long_press    <= long_d;
      repeat_pulse  <= repeat_d;
      held          <= held_d;
    end
`ifdef DOUBLE_CLICK_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      second       <= 1'b0;
      double_click <= 1'b0;
    end else begin
      second       <= second_d;
      double_click <= dclick_d;
    end
`else
  assign double_click = 1'b0;
`endif
endmodule

// File: tb/tb_button_event_decoder.sv
// tb_button_event_decoder: directed self-checking bench for button_event_decoder
module tb_button_event_decoder;
  logic clk = 1'b0, rst = 1'b0, clean = 1'b1;
  logic press, release_pulse, long_press, repeat_pulse, held, double_click;
  logic press0, release0, long0, repeat0, held0, dclick0;
  int vectors = 0, miscompares = 0;
  // output vector order: {press, release, long_press, repeat, held, double_click}
  localparam logic [5:0] Z  = 6'b000000;
  localparam logic [5:0] P  = 6'b100010;
  localparam logic [5:0] H  = 6'b000010;
  localparam logic [5:0] R  = 6'b010000;
  localparam logic [5:0] L  = 6'b001010;
  localparam logic [5:0] RP = 6'b000110;
`ifdef DOUBLE_CLICK_EN
  localparam logic [5:0] D2 = 6'b100011;
`else
  localparam logic [5:0] D2 = 6'b100010;
`endif
  always #5 clk = ~clk;
  button_event_decoder #(.CNT_W(8), .LONG_CYCLES(10), .REPEAT_CYCLES(4), .DCLICK_CYCLES(6)) dut (
    .clk(clk), .rst(rst), .clean(clean), .press(press), .release_pulse(release_pulse),
    .long_press(long_press), .repeat_pulse(repeat_pulse), .held(held), .double_click(double_click));
  button_event_decoder #(.CNT_W(8), .LONG_CYCLES(10), .REPEAT_CYCLES(0), .DCLICK_CYCLES(6)) dut0 (
    .clk(clk), .rst(rst), .clean(clean), .press(press0), .release_pulse(release0),
    .long_press(long0), .repeat_pulse(repeat0), .held(held0), .double_click(dclick0));
  wire [5:0] o  = {press, release_pulse, long_press, repeat_pulse, held, double_click};
  wire [5:0] o0 = {press0, release0, long0, repeat0, held0, dclick0};
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // drive clean, let one edge sample it, then check both instances (no-repeat copy never repeats)
  task automatic step(input string tag, input logic v, input logic [5:0] exp);
    clean = v;
    @(posedge clk);
    #1;
    chk(tag, {2'b0, o}, {2'b0, exp});
    chk({tag, "_r0"}, {2'b0, o0}, {2'b0, exp & 6'b111011 | (exp[2] ? H : Z)});
  endtask
  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, Z);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {2'b0, o}, 8'h00);
    chk("reset_count", dut.count, 8'h00);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) step("lockout_hold", 1'b1, Z);
    step("lockout_exit", 1'b0, Z);
    step("lockout_press", 1'b1, P);
    step("lockout_rel", 1'b0, R);
    idle("idle", 8);
    step("short_press", 1'b1, P);
    for (int i = 0; i < 4; i++) step("short_held", 1'b1, H);
    step("short_rel", 1'b0, R);
    idle("idle", 8);
    for (int k = 0; k < 25; k++)
      step("long_run", 1'b1, k == 0 ? P : k == 10 ? L : (k == 14 || k == 18 || k == 22) ? RP : H);
    step("long_rel", 1'b0, R);
    step("long_no_gap", 1'b0, Z);
    step("long_next_press", 1'b1, P);
    step("long_next_rel", 1'b0, R);
    idle("idle", 8);
    for (int k = 0; k < 10; k++) step("race_hold", 1'b1, k == 0 ? P : H);
    step("race_rel", 1'b0, R);
    idle("idle", 8);
    step("dc_p1", 1'b1, P);
    step("dc_h1", 1'b1, H);
    step("dc_h1", 1'b1, H);
    step("dc_r1", 1'b0, R);
    idle("dc_gap", 2);
    step("dc_p2", 1'b1, D2);
    step("dc_h2", 1'b1, H);
    step("dc_r2", 1'b0, R);
    step("dc_gap3", 1'b0, Z);
    step("dc_p3", 1'b1, P);
    step("dc_r3", 1'b0, R);
    idle("slow_gap", 6);
    step("slow_p", 1'b1, P);
    step("slow_r", 1'b0, R);
    idle("idle", 8);
    for (int k = 0; k < 12; k++) step("mid_hold", 1'b1, k == 0 ? P : k == 10 ? L : H);
    rst = 1'b0;
    #1;
    chk("mid_rst_outs", {2'b0, o}, 8'h00);
    chk("mid_rst_count", dut.count, 8'h00);
    @(posedge clk);
    #1;
    chk("mid_rst_norel", {2'b0, o}, 8'h00);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) step("post_rst_hold", 1'b1, Z);
    step("post_rst_exit", 1'b0, Z);
    step("post_rst_press", 1'b1, P);
    step("post_rst_rel", 1'b0, R);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
